// File: rtl/axi_lite_manager.sv
// axi_lite_manager: single-outstanding AXI4-Lite manager.
// Turns a valid/ready command into one AXI4-Lite write (AW/W/B) or read (AR/R)
// transaction and returns its completion on a valid/ready response port.
// All channel outputs are registered; no VALID depends combinationally on READY.
module axi_lite_manager #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ERRCNT_W = 16,
   localparam int unsigned STRB_W  = DATA_W / 8
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   // command port
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [STRB_W-1:0]   cmd_wstrb,
   // response port
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_write,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic [ERRCNT_W-1:0] err_count,
   // AXI write address / data / response
   output logic                AWVALID,
   input  logic                AWREADY,
   output logic [ADDR_W-1:0]   AWADDR,
   output logic                WVALID,
   input  logic                WREADY,
   output logic [DATA_W-1:0]   WDATA,
   output logic [STRB_W-1:0]   WSTRB,
   input  logic                BVALID,
   output logic                BREADY,
   input  logic [1:0]          BRESP,
   // AXI read address / data
   output logic                ARVALID,
   input  logic                ARREADY,
   output logic [ADDR_W-1:0]   ARADDR,
   input  logic                RVALID,
   output logic                RREADY,
   input  logic [DATA_W-1:0]   RDATA,
   input  logic [1:0]          RRESP
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WRESP,
      S_READ,
      S_RDATA,
      S_RSP
   } state_e;

   state_e              state_q;
   logic                cmd_ready_q;
   logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic [ADDR_W-1:0]   awaddr_q, araddr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic                rsp_valid_q, rsp_write_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic [1:0]          rsp_resp_q;
   logic [ERRCNT_W-1:0] err_q, err_d;

   // Saturating next value of the error counter; holds at all-ones.
   always_comb begin
      err_d = err_q;
      if (~&err_q) begin
         err_d = err_q + 1'b1;
      end
   end

   // Transaction FSM with all channel and response outputs registered.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         err_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // cmd_ready comes up one cycle after reset release, and is
               // re-armed directly by the response handshake otherwise.
               if (!cmd_ready_q) begin
                  cmd_ready_q <= 1'b1;
               end else if (cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  if (cmd_write) begin
                     awaddr_q  <= cmd_addr;
                     wdata_q   <= cmd_wdata;
                     wstrb_q   <= cmd_wstrb;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= S_WRITE;
                  end else begin
                     araddr_q  <= cmd_addr;
                     arvalid_q <= 1'b1;
                     state_q   <= S_READ;
                  end
               end
            end
            S_WRITE: begin
               // AW and W complete independently, in either order.
               if (awvalid_q && AWREADY) begin
                  awvalid_q <= 1'b0;
               end
               if (wvalid_q && WREADY) begin
                  wvalid_q <= 1'b0;
               end
               if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
                  bready_q <= 1'b1;
                  state_q  <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (BVALID) begin
                  bready_q    <= 1'b0;
                  rsp_write_q <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_resp_q  <= BRESP;
                  rsp_valid_q <= 1'b1;
                  if (BRESP != 2'b00) begin
                     err_q <= err_d;
                  end
                  state_q <= S_RSP;
               end
            end
            S_READ: begin
               if (ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (RVALID) begin
                  rready_q    <= 1'b0;
                  rsp_write_q <= 1'b0;
                  rsp_rdata_q <= RDATA;
                  rsp_resp_q  <= RRESP;
                  rsp_valid_q <= 1'b1;
                  if (RRESP != 2'b00) begin
                     err_q <= err_d;
                  end
                  state_q <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;
   assign err_count = err_q;
   assign AWVALID   = awvalid_q;
   assign AWADDR    = awaddr_q;
   assign WVALID    = wvalid_q;
   assign WDATA     = wdata_q;
   assign WSTRB     = wstrb_q;
   assign BREADY    = bready_q;
   assign ARVALID   = arvalid_q;
   assign ARADDR    = araddr_q;
   assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi_lite_manager.sv
// Testbench for axi_lite_manager: a memory-backed subordinate model with
// randomised ready timing, a table of directed vectors, hand-written
// back-pressure and reset sequences, and randomised commands checked against
// a word-level reference memory.
module tb_axi_lite_manager;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 64;
   localparam int unsigned EW   = 2;
   localparam int unsigned EMAX = 3;

   logic          ACLK = 1'b0;
   logic          ARESETn = 1'b0;
   logic          cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [7:0]    cmd_wstrb = '0;
   logic          rsp_ready = 1'b0;
   logic          cmd_ready, rsp_valid, rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [EW-1:0] err_count;
   logic          AWVALID, WVALID, BREADY, ARVALID, RREADY;
   logic [AW-1:0] AWADDR, ARADDR;
   logic [DW-1:0] WDATA;
   logic [7:0]    WSTRB;
   logic          AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
   logic [1:0]    BRESP = 2'b00, RRESP = 2'b00;
   logic [DW-1:0] RDATA = '0;

   axi_lite_manager #(.ADDR_W(AW), .DATA_W(DW), .ERRCNT_W(EW)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
   );

   initial forever #5 ACLK = ~ACLK;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- subordinate model (4 KiB byte memory) ----------------
   int unsigned   rdy_pct  = 100;
   bit            strict_w = 1'b1;   // WREADY only after the AW handshake
   bit            hold_b   = 1'b0;   // withhold the write response
   logic [7:0]    mem [0:4095] = '{default: 8'h00};
   bit            s_aw_ok = 0, s_w_ok = 0;
   logic [AW-1:0] s_awaddr = '0, cap_awaddr = '0, cap_araddr = '0;
   logic [DW-1:0] s_wdata = '0, cap_wdata = '0;
   logic [7:0]    s_wstrb = '0, cap_wstrb = '0;
   bit            hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0;
   bit            wait_aw = 0, wait_w = 0, wait_ar = 0;

   function automatic bit roll();
      return $urandom_range(99) < rdy_pct;
   endfunction

   // Everything changes at the falling edge; handshake flags computed here
   // describe what the following rising edge will see.
   always @(negedge ACLK) begin
      if (!ARESETn) begin
         AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
         BVALID = 1'b0; BRESP = 2'b00; RVALID = 1'b0; RRESP = 2'b00; RDATA = '0;
         s_aw_ok = 0; s_w_ok = 0;
         hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
         wait_aw = 0; wait_w = 0; wait_ar = 0;
      end else begin
         if (wait_aw) chk("aw_hold", {AWVALID, AWADDR}, {1'b1, cap_awaddr});
         if (wait_w)  chk("w_hold", {WVALID, WSTRB, WDATA}, {1'b1, cap_wstrb, cap_wdata});
         if (wait_ar) chk("ar_hold", {ARVALID, ARADDR}, {1'b1, cap_araddr});
         if (hs_aw) begin s_aw_ok = 1; s_awaddr = cap_awaddr; end
         if (hs_w)  begin s_w_ok = 1; s_wdata = cap_wdata; s_wstrb = cap_wstrb; end
         if (hs_b)  BVALID = 1'b0;
         if (hs_r)  RVALID = 1'b0;
         if (s_aw_ok && s_w_ok && !BVALID && !hold_b) begin
            if (s_awaddr < 32'd4096) begin
               for (int b = 0; b < 8; b++)
                  if (s_wstrb[b]) mem[(s_awaddr & 32'hFF8) + 32'(b)] = s_wdata[8*b +: 8];
               BRESP = 2'b00;
            end else begin
               BRESP = 2'b10;
            end
            BVALID = 1'b1; s_aw_ok = 0; s_w_ok = 0;
         end
         if (hs_ar) begin
            if (cap_araddr < 32'd4096) begin
               for (int b = 0; b < 8; b++) RDATA[8*b +: 8] = mem[(cap_araddr & 32'hFF8) + 32'(b)];
               RRESP = 2'b00;
            end else begin
               RDATA = '0; RRESP = 2'b10;
            end
            RVALID = 1'b1;
         end
         AWREADY = !s_aw_ok && roll();
         WREADY  = !s_w_ok && (!strict_w || s_aw_ok) && roll();
         ARREADY = !RVALID && roll();
         cap_awaddr = AWADDR; cap_wdata = WDATA; cap_wstrb = WSTRB; cap_araddr = ARADDR;
         hs_aw = AWVALID && AWREADY;  wait_aw = AWVALID && !AWREADY;
         hs_w  = WVALID && WREADY;    wait_w  = WVALID && !WREADY;
         hs_ar = ARVALID && ARREADY;  wait_ar = ARVALID && !ARREADY;
         hs_b  = BVALID && BREADY;
         hs_r  = RVALID && RREADY;
      end
   end

   // ---------------- command / response helpers ----------------
   task automatic start_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [7:0] s, output bit ok);
      int unsigned n = 0;
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
      ok = cmd_ready;
      @(negedge ACLK);
      // fields change after accept and must not affect the transaction
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom;
      cmd_wdata = {$urandom, $urandom}; cmd_wstrb = 8'($urandom);
   endtask

   task automatic wait_rsp(output int unsigned cyc, output bit ok);
      cyc = 0;
      while (!rsp_valid && cyc < 300) begin @(negedge ACLK); cyc++; end
      ok = rsp_valid;
      cyc++;   // the accept cycle itself is cycle 0
   endtask

   task automatic consume(input int unsigned dly, output logic [DW-1:0] rd,
                          output logic [1:0] rs, output logic rw);
      repeat (dly) @(negedge ACLK);
      rd = rsp_rdata; rs = rsp_resp; rw = rsp_write;
      rsp_ready = 1'b1;
      @(negedge ACLK);
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 1'b0);
   endtask

   task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [7:0] s, input int unsigned dly,
                         output logic [DW-1:0] rd, output logic [1:0] rs, output logic rw,
                         output int unsigned cyc, output bit ok);
      bit ok1, ok2;
      rd = '0; rs = 2'b11; rw = 1'bx; cyc = 0;
      start_cmd(wr, a, d, s, ok1);
      wait_rsp(cyc, ok2);
      ok = ok1 && ok2;
      if (ok) consume(dly, rd, rs, rw);
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [7:0] s);
      logic [DW-1:0] mask = '0;
      for (int b = 0; b < 8; b++) if (s[b]) mask[8*b +: 8] = 8'hFF;
      return (old & ~mask) | (nw & mask);
   endfunction

   // ---------------- directed vectors ----------------
   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [7:0]    strb;
      logic [DW-1:0] exp_rdata;
      logic [1:0]    exp_resp;
      int unsigned   exp_err;
   } vec_t;

   vec_t vt [12];

   logic [AW-1:0]   a;
   logic [DW-1:0]   d, rd, exp_rd, old;
   logic [7:0]      s;
   logic [1:0]      rs, exp_rs;
   logic            rw, w;
   logic [66:0]     snap;
   logic [DW-1:0]   ref_mem [int unsigned];
   int unsigned     cyc, n, err_m;
   bit              ok;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{1'b1, 32'h10,   64'h1122334455667788, 8'hFF, 64'h0,                2'b00, 0};
      vt[1]  = '{1'b0, 32'h10,   64'h0,                8'h00, 64'h1122334455667788, 2'b00, 0};
      vt[2]  = '{1'b1, 32'h10,   64'hAAAAAAAABBBBBBBB, 8'h0F, 64'h0,                2'b00, 0};
      vt[3]  = '{1'b0, 32'h10,   64'h0,                8'h00, 64'h11223344BBBBBBBB, 2'b00, 0};
      vt[4]  = '{1'b1, 32'h2000, 64'h5555666677778888, 8'hFF, 64'h0,                2'b10, 1};
      vt[5]  = '{1'b0, 32'h2000, 64'h0,                8'h00, 64'h0,                2'b10, 2};
      vt[6]  = '{1'b1, 32'h18,   64'h0102030405060708, 8'hA5, 64'h0,                2'b00, 2};
      vt[7]  = '{1'b0, 32'h18,   64'h0,                8'h00, 64'h0100030000060008, 2'b00, 2};
      vt[8]  = '{1'b1, 32'hFF8,  64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0,                2'b00, 2};
      vt[9]  = '{1'b0, 32'hFF8,  64'h0,                8'h00, 64'hDEADBEEFCAFEF00D, 2'b00, 2};
      vt[10] = '{1'b1, 32'h1000, 64'h1234,             8'hFF, 64'h0,                2'b10, 3};
      vt[11] = '{1'b0, 32'h1000, 64'h0,                8'h00, 64'h0,                2'b10, 3};

      // reset state
      repeat (3) @(negedge ACLK);
      chk("rst_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready, rsp_valid}, 7'b0);
      chk("rst_addr_data", {AWADDR, ARADDR, WDATA, WSTRB}, '0);
      chk("rst_rsp", {rsp_write, rsp_resp, rsp_rdata, err_count}, '0);
      rdy_pct = 100; strict_w = 1'b1;
      ARESETn = 1'b1;

      // table: always-ready subordinate, immediate response consumption
      foreach (vt[i]) begin
         do_cmd(vt[i].wr, vt[i].addr, vt[i].data, vt[i].strb, 0, rd, rs, rw, cyc, ok);
         chk($sformatf("v%0d_done", i), ok, 1'b1);
         chk($sformatf("v%0d_resp", i), rs, vt[i].exp_resp);
         chk($sformatf("v%0d_write", i), rw, vt[i].wr);
         chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
         chk($sformatf("v%0d_err", i), err_count, vt[i].exp_err);
         chk($sformatf("v%0d_latency", i), cyc, vt[i].wr ? 4 : 3);
      end

      // response back-pressure with a second command waiting
      start_cmd(1'b1, 32'h20, 64'h0F1E2D3C4B5A6978, 8'hFF, ok);
      chk("bp_accept1", ok, 1'b1);
      cmd_write = 1'b0; cmd_addr = 32'h20; cmd_valid = 1'b1;
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge ACLK); n++; end
      chk("bp_rsp1_seen", rsp_valid, 1'b1);
      chk("bp_rsp1_write", rsp_write, 1'b1);
      snap = {rsp_write, rsp_resp, rsp_rdata};
      for (int c = 0; c < 5; c++) begin
         chk("bp_hold_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, snap});
         chk("bp_hold_cmd_ready", cmd_ready, 1'b0);
         @(negedge ACLK);
      end
      rsp_ready = 1'b1;
      chk("bp_hs_cmd_ready", cmd_ready, 1'b0);
      @(negedge ACLK);
      rsp_ready = 1'b0;
      chk("bp_rsp_drop", rsp_valid, 1'b0);
      n = 0;
      while (!cmd_ready && n < 10) begin @(negedge ACLK); n++; end
      chk("bp_cmd2_ready", cmd_ready, 1'b1);
      @(negedge ACLK);
      cmd_valid = 1'b0;
      chk("bp_cmd2_taken", cmd_ready, 1'b0);
      wait_rsp(cyc, ok);
      chk("bp_rsp2_seen", ok, 1'b1);
      consume(1, rd, rs, rw);
      chk("bp_rsp2", {rw, rs, rd}, {1'b0, 2'b00, 64'h0F1E2D3C4B5A6978});

      // asynchronous reset while waiting for the write response
      hold_b = 1'b1;
      start_cmd(1'b1, 32'h30, 64'h99, 8'hFF, ok);
      chk("rst_mid_accept", ok, 1'b1);
      n = 0;
      while (!BREADY && n < 100) begin @(negedge ACLK); n++; end
      chk("rst_mid_wresp", BREADY, 1'b1);
      repeat (2) @(negedge ACLK);
      #2 ARESETn = 1'b0;
      #1;
      chk("rst_mid_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready, rsp_valid}, 7'b0);
      chk("rst_mid_regs", {AWADDR, WDATA, WSTRB, err_count}, '0);
      @(negedge ACLK);
      hold_b = 1'b0;
      @(negedge ACLK);
      ARESETn = 1'b1;
      do_cmd(1'b0, 32'h10, '0, '0, 0, rd, rs, rw, cyc, ok);
      chk("rst_after_done", ok, 1'b1);
      chk("rst_after_read", {rw, rs, rd, err_count}, {1'b0, 2'b00, 64'h11223344BBBBBBBB, 2'd0});

      // randomised commands against the reference memory
      err_m = 0;
      for (int k = 0; k < 40; k++) begin
         w = 1'($urandom_range(1));
         if ($urandom_range(6) == 0) a = 32'h1000 + 32'(8 * $urandom_range(31));
         else                        a = 32'h100 + 32'(8 * $urandom_range(7));
         d = {$urandom, $urandom};
         s = 8'($urandom);
         rdy_pct  = $urandom_range(100, 30);
         strict_w = 1'($urandom_range(1));
         exp_rd = '0;
         if (a < 32'd4096) begin
            exp_rs = 2'b00;
            old = ref_mem.exists(a) ? ref_mem[a] : '0;
            if (w) ref_mem[a] = merge(old, d, s);
            else   exp_rd = old;
         end else begin
            exp_rs = 2'b10;
            if (err_m < EMAX) err_m++;
         end
         do_cmd(w, a, d, s, $urandom_range(3), rd, rs, rw, cyc, ok);
         chk($sformatf("r%0d_done", k), ok, 1'b1);
         chk($sformatf("r%0d_rsp", k), {rw, rs, rd}, {w, exp_rs, exp_rd});
         chk($sformatf("r%0d_err", k), err_count, err_m);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
